if_prefetch: RTL

IF_PREFETCH -- requirements
Module: if_prefetch

---
 rtl/if_prefetch_pkg.sv | 19 +
 rtl/if_prefetch_fifo.sv | 59 +++++
 rtl/if_prefetch.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/if_prefetch_pkg.sv
// Shared definitions for the instruction prefetch unit:
// branch opcode, opcode field bounds and the fetch FSM states.
package if_prefetch_pkg;

  localparam logic [6:0] BRANCH_OP = 7'b1100011;
  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 6;

  typedef enum logic [1:0] {
    S_FETCH,
    S_PRED,
    S_DISCARD
  } state_t;

  function automatic logic is_branch_op(logic [OPC_MSB:OPC_LSB] opc);
    return opc == BRANCH_OP;
  endfunction

endpackage

// File: rtl/if_prefetch_fifo.sv
// Instruction queue: power-of-two ring buffer with flush,
// head presented combinationally (zero while empty).
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int DEPTH_I = DEPTH;
  localparam logic [AW:0] FULL_CNT = DEPTH_I[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = count == FULL_CNT;
  assign empty   = count == '0;
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetch: multi-beat fetch, branch prediction
// handshake, redirect/discard handling, and a decode-facing queue.
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int INST_BYTES = 4,
  parameter int MEM_BYTES  = 1,
  parameter int QDEPTH     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    redirect,
  input  logic [ADDR_W-1:0]       redirect_pc,
  output logic                    mem_req,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic                    mem_rvalid,
  input  logic [8*MEM_BYTES-1:0]  mem_rdata,
  output logic                    pred_req,
  output logic [ADDR_W-1:0]       pred_pc,
  input  logic                    pred_valid,
  input  logic                    pred_taken,
  input  logic [ADDR_W-1:0]       pred_target,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDR_W-1:0]       out_pc,
  output logic [8*INST_BYTES-1:0] out_inst,
  output logic                    out_jump
);

  localparam int BEATS = INST_BYTES / MEM_BYTES;
  localparam int BW    = 8 * MEM_BYTES;
  localparam int IW    = 8 * INST_BYTES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int EW    = ADDR_W + IW + 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  if (MEM_BYTES < 1 || INST_BYTES % MEM_BYTES != 0) begin : g_bad_beat
    $error("INST_BYTES must be a multiple of MEM_BYTES");
  end
  if (QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0) begin : g_bad_depth
    $error("QDEPTH must be a power of two >= 2");
  end

  state_t                 state;
  logic [ADDR_W-1:0]      fetch_pc;
  logic [CW-1:0]          beat;
  logic [IW-1:0]          inst_buf;
  logic [IW-1:0]          inst_new;
  logic [ADDR_W-1:0]      next_pc;
  logic [ADDR_W-1:0]      beat_addr;
  logic                   last_beat;
  logic                   branch;
  logic                   fetch_push;
  logic                   pred_push;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   empty;
  logic [EW-1:0]          wdata;
  logic [EW-1:0]          rdata;
  logic [$clog2(QDEPTH):0] count;

  always_comb begin
    inst_new = inst_buf;
    inst_new[int'(beat)*BW +: BW] = mem_rdata;
  end

  assign next_pc   = fetch_pc + ADDR_W'(INST_BYTES);
  assign beat_addr = fetch_pc + ADDR_W'(beat) * ADDR_W'(MEM_BYTES);
  assign last_beat = beat == LAST;
  assign branch    = is_branch_op(inst_new[OPC_MSB:OPC_LSB]);

  assign fetch_push = (state == S_FETCH) && mem_req && mem_rvalid
                   && last_beat && !branch && !redirect;
  assign pred_push  = (state == S_PRED) && pred_valid && !full
                   && !redirect;
  assign push = fetch_push || pred_push;
  assign pop  = out_valid && out_ready && !redirect;

  assign wdata = {fetch_pc,
                  pred_push ? inst_buf : inst_new,
                  pred_push && pred_taken};

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata (wdata),
    .rdata (rdata),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign out_valid = !empty;
  assign {out_pc, out_inst, out_jump} = rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_FETCH;
      fetch_pc <= '0;
      beat     <= '0;
      inst_buf <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      pred_req <= 1'b0;
      pred_pc  <= '0;
    end else begin
      unique case (state)
        S_FETCH: begin
          if (redirect) begin
            fetch_pc <= redirect_pc;
            beat     <= '0;
            inst_buf <= '0;
            // An unanswered beat must still be drained.
            if (mem_req && !mem_rvalid) state <= S_DISCARD;
            else mem_req <= 1'b0;
          end else if (mem_req) begin
            if (mem_rvalid) begin
              mem_req <= 1'b0;
              if (last_beat) begin
                beat <= '0;
                if (branch) begin
                  state    <= S_PRED;
                  pred_req <= 1'b1;
                  pred_pc  <= fetch_pc;
                  inst_buf <= inst_new;
                end else begin
                  fetch_pc <= next_pc;
                  inst_buf <= '0;
                end
              end else begin
                beat     <= beat + 1'b1;
                inst_buf <= inst_new;
              end
            end
          end else if (beat != '0 || int'(count) < QDEPTH) begin
            mem_req  <= 1'b1;
            mem_addr <= beat_addr;
          end
        end
        S_PRED: begin
          if (redirect) begin
            fetch_pc <= redirect_pc;
            pred_req <= 1'b0;
            inst_buf <= '0;
            state    <= S_FETCH;
          end else if (pred_valid && !full) begin
            fetch_pc <= pred_taken ? pred_target : next_pc;
            pred_req <= 1'b0;
            inst_buf <= '0;
            state    <= S_FETCH;
          end
        end
        S_DISCARD: begin
          if (redirect) fetch_pc <= redirect_pc;
          if (mem_rvalid) begin
            mem_req <= 1'b0;
            state   <= S_FETCH;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule
